// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access sizes, writeback sources, FSM states.
// Also holds the alignment rule and access-size decode used by the stage and its bench.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam logic [1:0] SRC_PC4  = 2'b00;
    localparam logic [1:0] SRC_ALU  = 2'b01;
    localparam logic [1:0] SRC_FPU  = 2'b10;
    localparam logic [1:0] SRC_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Dword is only a legal size on a 64-bit datapath.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr,
                                        input logic xlen64);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = !xlen64 || (addr != 3'b000);
        endcase
        return bad;
    endfunction

    function automatic int access_bytes(input logic [1:0] size);
        int nb;
        case (size)
            SZ_BYTE: nb = 1;
            SZ_HALF: nb = 2;
            SZ_WORD: nb = 4;
            default: nb = 8;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Big-endian load lane extraction: shifts the addressed bytes to the top of the word,
// then brings them down with a sign- or zero-filling right shift.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [OFFW-1:0] offset,
    input  logic [1:0]      size,
    input  logic            ext,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0]        top_aligned;
    logic signed [XLEN-1:0] top_s;
    logic [6:0]             sh;

    always_comb begin
        // Offset 0 is the most-significant lane, so a left shift drops the leading lanes.
        top_aligned = rdata << {offset, 3'b000};
        top_s       = top_aligned;
        case (size)
            SZ_BYTE: sh = 7'(XLEN - 8);
            SZ_HALF: sh = 7'(XLEN - 16);
            SZ_WORD: sh = 7'(XLEN - 32);
            default: sh = 7'd0;
        endcase
        if (ext) data = top_s >>> sh;
        else     data = top_aligned >> sh;
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Memory pipeline stage: captures one instruction, issues a single data-memory
// request for aligned loads/stores, and presents the writeback slot.
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int RA_W = 6,
    localparam int BE_W = XLEN / 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_fpu,
    input  logic [XLEN-1:0] in_regb,
    input  logic [XLEN-1:0] in_pc4,
    input  logic [1:0]      in_din_src,
    input  logic            in_reg_we,
    input  logic [RA_W-1:0] in_reg_waddr,
    input  logic            in_mem_re,
    input  logic            in_mem_we,
    input  logic [1:0]      in_mem_size,
    input  logic            in_ext,
    output logic            stall_out,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [BE_W-1:0] dm_be,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_reg_we,
    output logic [RA_W-1:0] wb_reg_waddr,
    output logic            misalign_err
);

    localparam int OFFW = $clog2(BE_W);

    state_e          state_q, state_d;
    logic            valid_q, reg_we_q, mem_re_q, mem_we_q, ext_q, mis_q;
    logic [XLEN-1:0] alu_q, fpu_q, regb_q, pc4_q, ld_q, ld_aligned;
    logic [1:0]      din_src_q, size_q;
    logic [RA_W-1:0] waddr_q;
    logic            load_en, in_mem_op, in_mis;
    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] wdata_c;

    assign load_en   = !stall_out && !stall;
    assign in_mem_op = in_mem_re || in_mem_we;
    assign in_mis    = in_mem_op && misaligned(in_mem_size, in_alu[2:0], XLEN == 64);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            alu_q     <= '0;
            fpu_q     <= '0;
            regb_q    <= '0;
            pc4_q     <= '0;
            din_src_q <= '0;
            reg_we_q  <= 1'b0;
            waddr_q   <= '0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            size_q    <= '0;
            ext_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else if (load_en) begin
            valid_q   <= in_valid;
            alu_q     <= in_alu;
            fpu_q     <= in_fpu;
            regb_q    <= in_regb;
            pc4_q     <= in_pc4;
            din_src_q <= in_din_src;
            reg_we_q  <= in_reg_we;
            waddr_q   <= in_reg_waddr;
            mem_re_q  <= in_mem_re;
            mem_we_q  <= in_mem_we;
            size_q    <= in_mem_size;
            ext_q     <= in_ext;
            mis_q     <= in_mis;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          ld_q <= '0;
        else if (state_q == ST_BUSY && dm_ack && mem_re_q) ld_q <= ld_aligned;
    end

    // A capture while in DONE goes straight to BUSY, so back-to-back memory ops see no bubble.
    always_comb begin
        state_d = state_q;
        if (load_en)
            state_d = (in_valid && in_mem_op && !in_mis) ? ST_BUSY : ST_IDLE;
        else if (state_q == ST_BUSY && dm_ack)
            state_d = ST_DONE;
    end

    mem_load_align #(.XLEN(XLEN)) u_align (
        .rdata  (dm_rdata),
        .offset (alu_q[OFFW-1:0]),
        .size   (size_q),
        .ext    (ext_q),
        .data   (ld_aligned)
    );

    // Byte enable j covers data bits [8j+7:8j], i.e. address offset BE_W-1-j.
    always_comb begin
        int nb, off, lane;
        be_c    = '0;
        wdata_c = '0;
        nb      = access_bytes(size_q);
        off     = int'(alu_q[OFFW-1:0]);
        for (int j = 0; j < BE_W; j++) begin
            lane              = BE_W - 1 - j;
            be_c[j]           = (lane >= off) && (lane < off + nb);
            wdata_c[8*j +: 8] = regb_q[8*(j & (nb - 1)) +: 8];
        end
    end

    // Handshake: dm_req stays high with fields frozen from the stage register until a
    // cycle with dm_ack=1 completes it; exactly one such cycle occurs per request.
    always_comb begin
        stall_out    = (state_q == ST_BUSY);
        dm_req       = (state_q == ST_BUSY);
        dm_we        = dm_req && mem_we_q;
        dm_addr      = dm_req ? alu_q : '0;
        dm_be        = dm_req ? be_c : '0;
        dm_wdata     = dm_req ? wdata_c : '0;
        wb_valid     = valid_q && (state_q != ST_BUSY);
        wb_reg_we    = wb_valid && reg_we_q && !mis_q;
        wb_reg_waddr = waddr_q;
        misalign_err = wb_valid && mis_q;
        case (din_src_q)
            SRC_PC4: wb_data = pc4_q;
            SRC_ALU: wb_data = alu_q;
            SRC_FPU: wb_data = fpu_q;
            default: wb_data = ld_q;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: table of single-cycle ops plus directed
// sequences for loads, stores, stall hold, back-to-back ops and reset in BUSY.
module tb_mem_stage_hs;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, stall, in_valid;
    logic [31:0] in_alu, in_fpu, in_regb, in_pc4;
    logic [1:0]  in_din_src, in_mem_size;
    logic        in_reg_we, in_mem_re, in_mem_we, in_ext;
    logic [5:0]  in_reg_waddr;
    logic        stall_out, dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, wb_data;
    logic [3:0]  dm_be;
    logic        wb_valid, wb_reg_we, misalign_err;
    logic [5:0]  wb_reg_waddr;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int hs_count  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  din_src;
        logic [31:0] alu, fpu, regb, pc4;
        logic        reg_we;
        logic [5:0]  waddr;
        logic        re, we;
        logic [1:0]  size;
        logic        ext;
        logic [31:0] exp_data;
        logic        exp_we, exp_mis;
    } vec_t;

    mem_stage_hs dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
        .in_alu(in_alu), .in_fpu(in_fpu), .in_regb(in_regb), .in_pc4(in_pc4),
        .in_din_src(in_din_src), .in_reg_we(in_reg_we), .in_reg_waddr(in_reg_waddr),
        .in_mem_re(in_mem_re), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
        .in_ext(in_ext), .stall_out(stall_out), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_reg_we(wb_reg_we), .wb_reg_waddr(wb_reg_waddr), .misalign_err(misalign_err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // handshake monitor, sampled mid-cycle
    always @(negedge clk) if (dm_req && dm_ack) hs_count++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [1:0] din_src, input logic [31:0] alu, fpu, regb, pc4,
                                input logic reg_we, input logic [5:0] waddr, input logic re, we,
                                input logic [1:0] size, input logic ext,
                                input logic [31:0] exp_data, input logic exp_we, exp_mis);
        vec_t v;
        v.din_src = din_src; v.alu = alu; v.fpu = fpu; v.regb = regb; v.pc4 = pc4;
        v.reg_we = reg_we; v.waddr = waddr; v.re = re; v.we = we; v.size = size; v.ext = ext;
        v.exp_data = exp_data; v.exp_we = exp_we; v.exp_mis = exp_mis;
        return v;
    endfunction

    // driver tasks
    task automatic drive(input vec_t v);
        in_valid = 1'b1;     in_din_src = v.din_src; in_alu = v.alu;  in_fpu = v.fpu;
        in_regb = v.regb;    in_pc4 = v.pc4;         in_reg_we = v.reg_we;
        in_reg_waddr = v.waddr; in_mem_re = v.re;    in_mem_we = v.we;
        in_mem_size = v.size;   in_ext = v.ext;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Acts as the memory: acks on the wait_n-th BUSY cycle; reports BUSY length and
    // whether the request fields stayed frozen.
    task automatic serve(input int wait_n, input logic [31:0] rdata, output int busy,
                         output logic stable);
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        busy = 0; stable = 1'b1;
        a0 = dm_addr; w0 = dm_wdata; b0 = dm_be; we0 = dm_we;
        for (int c = 0; c < 64; c++) begin
            if (!stall_out) break;
            busy++;
            if (!dm_req || dm_addr !== a0 || dm_wdata !== w0 || dm_be !== b0 || dm_we !== we0)
                stable = 1'b0;
            if (busy == wait_n) begin
                dm_ack = 1'b1; dm_rdata = rdata;
            end
            tick();
            dm_ack = 1'b0;
        end
    endtask

    task automatic check_wb(input string tag, input vec_t v);
        check({tag, "_wb_valid"}, wb_valid, 1);
        check({tag, "_wb_data"}, wb_data, v.exp_data);
        check({tag, "_wb_reg_we"}, wb_reg_we, v.exp_we);
        check({tag, "_wb_waddr"}, wb_reg_waddr, v.waddr);
        check({tag, "_misalign"}, misalign_err, v.exp_mis);
    endtask

    vec_t tbl[8];
    vec_t v, v2;
    int   busy, hs0;
    logic stable;

    initial begin
        tbl[0] = mk(SRC_LOAD, 32'h40, 0, 0, 0, 1, 6'd3, 0, 0, SZ_WORD, 0, 32'h0, 1, 0);
        tbl[1] = mk(SRC_ALU, 32'h1234, 0, 0, 0, 1, 6'd1, 0, 0, SZ_WORD, 0, 32'h0000_1234, 1, 0);
        tbl[2] = mk(SRC_PC4, 32'h55, 0, 0, 32'h2000_0004, 0, 6'd2, 0, 0, SZ_BYTE, 0, 32'h2000_0004, 0, 0);
        tbl[3] = mk(SRC_FPU, 32'h9, 32'h3F80_0000, 0, 0, 1, 6'd63, 0, 0, SZ_HALF, 1, 32'h3F80_0000, 1, 0);
        tbl[4] = mk(SRC_LOAD, 32'h106, 0, 0, 0, 1, 6'd4, 1, 0, SZ_WORD, 0, 32'h0, 0, 1);
        tbl[5] = mk(SRC_ALU, 32'h101, 0, 0, 0, 1, 6'd6, 1, 0, SZ_HALF, 1, 32'h101, 0, 1);
        tbl[6] = mk(SRC_ALU, 32'h100, 0, 0, 0, 1, 6'd7, 1, 0, SZ_DWORD, 0, 32'h100, 0, 1);
        tbl[7] = mk(SRC_ALU, 32'h103, 0, 32'h77, 0, 0, 6'd8, 0, 1, SZ_WORD, 0, 32'h103, 0, 1);

        reset = 1'b1; stall = 1'b0; in_valid = 1'b0; in_alu = '0; in_fpu = '0; in_regb = '0;
        in_pc4 = '0; in_din_src = '0; in_reg_we = 1'b0; in_reg_waddr = '0; in_mem_re = 1'b0;
        in_mem_we = 1'b0; in_mem_size = '0; in_ext = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        tick();
        check("rst_dm_req", dm_req, 0);
        check("rst_stall_out", stall_out, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_dm_be", dm_be, 0);
        check("rst_misalign", misalign_err, 0);
        tick();
        reset = 1'b0;

        // single-cycle ops: non-memory and misaligned
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            tick();
            in_valid = 1'b0;
            check($sformatf("tbl%0d_dm_req", i), dm_req, 0);
            check($sformatf("tbl%0d_stall_out", i), stall_out, 0);
            check_wb($sformatf("tbl%0d", i), tbl[i]);
        end
        tick();
        check("bubble_wb_valid", wb_valid, 0);

        // signed byte load at offset 1, acked on the third BUSY cycle
        v = mk(SRC_LOAD, 32'h101, 0, 0, 0, 1, 6'd5, 1, 0, SZ_BYTE, 1, 32'hFFFF_FFF3, 1, 0);
        drive(v); tick(); in_valid = 1'b0;
        check("ldb_wb_valid_busy", wb_valid, 0);
        check("ldb_dm_addr", dm_addr, 32'h101);
        check("ldb_dm_be", dm_be, 4'b0100);
        check("ldb_dm_we", dm_we, 0);
        serve(3, 32'h11F3_5566, busy, stable);
        check("ldb_stall_cycles", busy, 3);
        check("ldb_req_stable", stable, 1);
        check_wb("ldb", v);

        // byte store at offset 3: lowest lane, replicated data
        v = mk(SRC_ALU, 32'h103, 0, 32'h5A, 0, 0, 6'd10, 0, 1, SZ_BYTE, 0, 32'h103, 0, 0);
        drive(v); tick(); in_valid = 1'b0;
        check("stb_dm_be", dm_be, 4'b0001);
        check("stb_dm_wdata", dm_wdata, 32'h5A5A_5A5A);
        check("stb_dm_we", dm_we, 1);
        serve(1, 32'h0, busy, stable);
        check("stb_busy", busy, 1);
        check_wb("stb", v);

        // half store with stall held for 5 cycles: one handshake, wb holds, no capture
        v = mk(SRC_ALU, 32'h102, 0, 32'hABCD, 0, 0, 6'd11, 0, 1, SZ_HALF, 0, 32'h102, 0, 0);
        hs0 = hs_count;
        drive(v); tick(); in_valid = 1'b0;
        check("sth_dm_be", dm_be, 4'b0011);
        check("sth_dm_wdata", dm_wdata, 32'hABCD_ABCD);
        check("sth_dm_addr", dm_addr, 32'h102);
        stall = 1'b1;
        serve(2, 32'h0, busy, stable);
        check("sth_busy", busy, 2);
        check("sth_req_stable", stable, 1);
        v2 = mk(SRC_ALU, 32'h77, 0, 0, 0, 1, 6'd12, 0, 0, SZ_WORD, 0, 32'h77, 1, 0);
        drive(v2);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("sth_hold%0d_wb_valid", c), wb_valid, 1);
            check($sformatf("sth_hold%0d_wb_data", c), wb_data, 32'h102);
            check($sformatf("sth_hold%0d_dm_req", c), dm_req, 0);
            tick();
        end
        check("sth_handshakes", hs_count - hs0, 1);
        stall = 1'b0;
        tick(); in_valid = 1'b0;
        check_wb("after_stall", v2);

        // back-to-back loads, zero-wait acks: DONE -> BUSY with no bubble, results in order
        v  = mk(SRC_LOAD, 32'h100, 0, 0, 0, 1, 6'd13, 1, 0, SZ_HALF, 0, 32'h0000_8001, 1, 0);
        v2 = mk(SRC_LOAD, 32'h102, 0, 0, 0, 1, 6'd14, 1, 0, SZ_HALF, 1, 32'hFFFF_F00D, 1, 0);
        exp_q.push_back(v.exp_data);
        exp_q.push_back(v2.exp_data);
        drive(v); tick();
        check("b2b_first_req", dm_req, 1);
        drive(v2);
        dm_ack = 1'b1; dm_rdata = 32'h8001_2345;
        tick(); dm_ack = 1'b0;
        check("b2b_first_done_valid", wb_valid, 1);
        check("b2b_first_data", wb_data, exp_q.pop_front());
        check("b2b_first_done_stall", stall_out, 0);
        tick(); in_valid = 1'b0;
        check("b2b_second_req", dm_req, 1);
        check("b2b_second_addr", dm_addr, 32'h102);
        check("b2b_second_busy_valid", wb_valid, 0);
        dm_ack = 1'b1; dm_rdata = 32'h1234_F00D;
        tick(); dm_ack = 1'b0;
        check("b2b_second_valid", wb_valid, 1);
        check("b2b_second_data", wb_data, exp_q.pop_front());
        check("b2b_second_waddr", wb_reg_waddr, 14);

        // reset while BUSY aborts the request and the writeback
        v = mk(SRC_LOAD, 32'h104, 0, 0, 0, 1, 6'd9, 1, 0, SZ_WORD, 0, 32'hDEAD_BEEF, 1, 0);
        drive(v); tick(); in_valid = 1'b0;
        check("rbusy_req_before", dm_req, 1);
        reset = 1'b1; #1;
        check("rbusy_dm_req", dm_req, 0);
        check("rbusy_wb_valid", wb_valid, 0);
        check("rbusy_stall_out", stall_out, 0);
        tick(); reset = 1'b0;
        tick();
        check("rbusy_no_wb", wb_valid, 0);
        drive(tbl[0]); tick(); in_valid = 1'b0;
        check_wb("post_rst_ldq", tbl[0]);
        drive(v); tick(); in_valid = 1'b0;
        serve(2, 32'hDEAD_BEEF, busy, stable);
        check("post_rst_busy", busy, 2);
        check_wb("post_rst_load", v);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter RA_W, default 6, register write-address width.
REQ-003 Parameter BE_W, default XLEN/8, byte-enable width; this value is derived and is not overridden.
REQ-004 Ports, in this order:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  global hold.
- in_valid  in  1  upstream instruction valid.
- in_alu, in_fpu, in_regb, in_pc4  in  XLEN  each  ALU result / memory address; FPU result; store data; PC+4.
- in_din_src  in  2  writeback source select.
- in_reg_we  in  1  register write enable.
- in_reg_waddr  in  RA_W  register write address.
- in_mem_re, in_mem_we  in  1  each  load / store.
- in_mem_size  in  2  access size.
- in_ext  in  1  sign-extend loads.
- stall_out  out  1  stage busy; hold upstream.
- dm_req  out  1  memory request.
- dm_we  out  1  request is a write.
- dm_addr  out  XLEN  request address.
- dm_wdata  out  XLEN  write data.
- dm_be  out  BE_W  byte enables.
- dm_ack  in  1  request accepted / read data valid.
- dm_rdata  in  XLEN  read data.
- wb_valid  out  1  writeback slot valid.
- wb_data  out  XLEN  writeback data.
- wb_reg_we  out  1  writeback register write enable.
- wb_reg_waddr  out  RA_W  writeback register address.
- misalign_err  out  1  misaligned or illegal access.

Function
REQ-005 The stage register (all in_* fields plus the valid bit) SHALL load on a clk edge when stall_out=0 and stall=0, and SHALL hold otherwise.
REQ-006 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-007 On load of a valid, aligned memory operation (in_mem_re or in_mem_we), the next state SHALL be BUSY; on load of any other instruction it SHALL be IDLE.
REQ-008 In BUSY, dm_req SHALL equal 1 and stall_out SHALL equal 1. When dm_ack=1 the FSM SHALL move to DONE; if the op is a load, it SHALL register the aligned and extended dm_rdata into ld_q on the same edge.
REQ-009 Each stored instruction SHALL issue exactly one dm_req handshake, irrespective of stall; stall SHALL NOT abort BUSY.
REQ-010 wb_valid SHALL be 1 when the register valid bit is set and state is IDLE or DONE; wb_valid, wb_data and wb_reg_* SHALL hold while stall=1.
REQ-011 Latency: non-memory ops SHALL have wb_valid 1 cycle after capture; memory ops SHALL have wb_valid 1 cycle after the dm_ack cycle.
REQ-012 wb_data SHALL be selected by din_src: 00 pc4, 01 alu, 10 fpu, 11 ld_q.
REQ-013 Size encoding SHALL be: 00 byte, 01 half, 10 word, 11 dword. Dword SHALL be legal only when XLEN=64.
REQ-014 Byte ordering SHALL be big-endian: address offset 0 maps to the most-significant lane.
REQ-015 dm_be SHALL mark exactly the accessed lanes; dm_wdata SHALL carry the store data replicated into every lane slot of the access size.
REQ-016 Load data SHALL be extracted from the addressed lanes; it SHALL be sign-extended when ext=1 and zero-extended otherwise.
REQ-017 A half access at an odd address, a word access with addr[1:0]!=0, a dword access with addr[2:0]!=0, or dword with XLEN=32 SHALL NOT raise dm_req. Such an op SHALL complete as a non-memory op with wb_reg_we forced to 0 and misalign_err=1 while it occupies the wb slot.
REQ-018 A capture in DONE SHALL make a back-to-back memory op go DONE->BUSY with no IDLE bubble.
REQ-019 dm_addr, dm_we, dm_be and dm_wdata SHALL be stable for the whole time dm_req=1.

Reset
REQ-020 Reset SHALL asynchronously clear the state to IDLE, the valid bit, ld_q and all register fields to 0, so that every output is 0, including dm_req.
REQ-021 Reset during BUSY SHALL drop dm_req immediately, and the aborted op SHALL produce no writeback.

Structure
REQ-022 Package mem_stage_pkg SHALL hold the size encodings, the din_src encodings and the FSM state enum.
REQ-023 Lane extraction and extension SHALL be implemented in one combinational sub-module, mem_load_align.

Verification
REQ-024 ALU op with din_src=01 and alu=0x1234 -> wb_valid=1 and wb_data=0x00001234 one cycle later, stall_out=0 throughout.
REQ-025 Byte load with ext=1 at addr 0x101, rdata=0x11F3_5566 (lane at offset 1 is 0xF3), ack after 3 cycles -> stall_out=1 for 3 cycles, then wb_data=0xFFFF_FFF3.
REQ-026 Half store at addr 0x102 with regb=0xABCD -> dm_be=0011, dm_wdata=0xABCD_ABCD, exactly one req/ack, even with stall=1 held for 5 cycles.
REQ-027 Word load at addr 0x106 -> no dm_req, misalign_err=1, wb_reg_we=0.
REQ-028 Reset asserted in BUSY -> dm_req and wb_valid are 0 that cycle; after reset, a new op completes normally.
REQ-029 Two consecutive loads with ack at zero wait -> BUSY, DONE, BUSY, DONE, with both results in order.
